// File: rtl/bp_update_ctrl.sv
// Branch-predictor PHT update controller: clears the table after reset, queues
// resolved-branch reports and applies them read-modify-write, arbitrating the read port with fetch.
module bp_update_ctrl #(
  parameter int IDX_W      = 8,
  parameter int Q_DEPTH    = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_index,
  input  logic             upd_taken,
  output logic             upd_ready,
  input  logic             flush,
  input  logic             lkp_valid,
  input  logic [IDX_W-1:0] lkp_index,
  output logic             lkp_grant,
  output logic [IDX_W-1:0] rd_idx,
  input  logic [1:0]       rd_data,
  output logic             pht_we,
  output logic [IDX_W-1:0] pht_widx,
  output logic [1:0]       pht_wdata,
  output logic             init_busy
);

  localparam int PTR_W = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam int CNT_W = $clog2(Q_DEPTH) + 1;
  localparam int SW    = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {INIT, IDLE, READ, WRITE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] init_cnt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [PTR_W-1:0] wptr, rptr;
  logic [SW-1:0]    starve_cnt, starve_nxt;
  logic [1:0]       cur_ctr, upd_ctr;

  logic [IDX_W-1:0] q_idx [Q_DEPTH];
  logic             q_tkn [Q_DEPTH];

  logic [IDX_W-1:0] head_idx;
  logic             head_tkn;
  logic             push, pop, flush_act;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(Q_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_idx  = q_idx[rptr];
  assign head_tkn  = q_tkn[rptr];
  assign upd_ready = (state != INIT) && (count < CNT_W'(Q_DEPTH)) && !flush;
  assign push      = upd_valid && upd_ready;
  assign pop       = (state == WRITE);
  assign flush_act = flush && (state != INIT);

  always_comb begin
    upd_ctr = cur_ctr;
    if (head_tkn) begin
      if (cur_ctr != 2'b11) upd_ctr = cur_ctr + 2'd1;
    end else begin
      if (cur_ctr != 2'b00) upd_ctr = cur_ctr - 2'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    init_busy = 1'b0;
    lkp_grant = 1'b0;
    rd_idx    = lkp_index;
    pht_we    = 1'b0;
    pht_widx  = head_idx;
    pht_wdata = upd_ctr;
    case (state)
      INIT: begin
        init_busy = 1'b1;
        pht_we    = 1'b1;
        pht_widx  = init_cnt;
        pht_wdata = 2'b01;
        if (init_cnt == '1) state_nxt = IDLE;
      end
      IDLE: begin
        lkp_grant = lkp_valid;
        // A flushed queue must not start a read of an entry that is being dropped
        if (!flush && (count != '0) &&
            (!lkp_valid || (starve_cnt == SW'(STARVE_MAX))))
          state_nxt = READ;
      end
      READ: begin
        rd_idx    = head_idx;
        state_nxt = flush ? IDLE : WRITE;
      end
      WRITE: begin
        lkp_grant = lkp_valid;
        pht_we    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = INIT;
    endcase
  end

  always_comb begin
    starve_nxt = starve_cnt;
    if (state == IDLE) begin
      if (state_nxt == READ)
        starve_nxt = '0;
      else if ((count != '0) && lkp_valid && (starve_cnt < SW'(STARVE_MAX)))
        starve_nxt = starve_cnt + 1'b1;
    end
  end

  always_comb begin
    count_nxt = count;
    if (flush_act)
      count_nxt = '0;
    else begin
      case ({push, pop})
        2'b10:   count_nxt = count + 1'b1;
        2'b01:   count_nxt = count - 1'b1;
        default: count_nxt = count;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= INIT;
      init_cnt   <= '0;
      count      <= '0;
      wptr       <= '0;
      rptr       <= '0;
      starve_cnt <= '0;
      cur_ctr    <= 2'b00;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      starve_cnt <= starve_nxt;
      if (state == INIT) init_cnt <= init_cnt + 1'b1;
      if (state == READ) cur_ctr <= rd_data;
      // Flush drops everything unstarted; a write in progress has already used the head
      if (flush_act)
        rptr <= wptr;
      else if (pop)
        rptr <= ptr_inc(rptr);
      if (push) wptr <= ptr_inc(wptr);
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      q_idx[wptr] <= upd_index;
      q_tkn[wptr] <= upd_taken;
    end
  end

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Directed self-checking bench for bp_update_ctrl: table clear, counter updates,
// starvation arbitration, flush handling and reset during a write.
module tb_bp_update_ctrl;
  localparam int IDX_W = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_index;
  logic             upd_taken;
  logic             upd_ready;
  logic             flush;
  logic             lkp_valid;
  logic [IDX_W-1:0] lkp_index;
  logic             lkp_grant;
  logic [IDX_W-1:0] rd_idx;
  logic [1:0]       rd_data;
  logic             pht_we;
  logic [IDX_W-1:0] pht_widx;
  logic [1:0]       pht_wdata;
  logic             init_busy;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  bp_update_ctrl #(.IDX_W(IDX_W), .Q_DEPTH(4), .STARVE_MAX(4)) dut (
    .clock(clock), .reset(reset),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken),
    .upd_ready(upd_ready), .flush(flush),
    .lkp_valid(lkp_valid), .lkp_index(lkp_index), .lkp_grant(lkp_grant),
    .rd_idx(rd_idx), .rd_data(rd_data),
    .pht_we(pht_we), .pht_widx(pht_widx), .pht_wdata(pht_wdata),
    .init_busy(init_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Entered one step after reset release; expects exactly 256 clear writes of 01.
  task automatic run_init(input string tag);
    int bad = 0;
    lkp_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      #1;
      if (!(pht_we === 1'b1 && pht_widx === IDX_W'(i) && pht_wdata === 2'b01 &&
            init_busy === 1'b1 && upd_ready === 1'b0 && lkp_grant === 1'b0))
        bad++;
      tick();
    end
    chk({tag, "_clear_seq_bad"}, bad, 0);
    #1;
    chk({tag, "_init_busy_done"}, init_busy, 1'b0);
    chk({tag, "_ready_done"}, upd_ready, 1'b1);
    lkp_valid = 1'b0;
  endtask

  task automatic do_update(input string tag, input logic [7:0] idx, input logic tk,
                           input logic [1:0] rd, input logic [1:0] exp);
    upd_valid = 1'b1; upd_index = idx; upd_taken = tk; lkp_valid = 1'b0;
    #1 chk({tag, "_ready"}, upd_ready, 1'b1);
    tick();
    upd_valid = 1'b0;
    #1 chk({tag, "_idle_we"}, pht_we, 1'b0);
    tick();
    rd_data = rd; lkp_valid = 1'b1; lkp_index = 8'h33;
    #1 chk({tag, "_read_idx"}, rd_idx, idx);
    chk({tag, "_read_grant"}, lkp_grant, 1'b0);
    chk({tag, "_read_we"}, pht_we, 1'b0);
    tick();
    #1 chk({tag, "_wr_we"}, pht_we, 1'b1);
    chk({tag, "_wr_idx"}, pht_widx, idx);
    chk({tag, "_wr_data"}, pht_wdata, exp);
    chk({tag, "_wr_grant"}, lkp_grant, 1'b1);
    chk({tag, "_wr_rdidx"}, rd_idx, 8'h33);
    tick();
    lkp_valid = 1'b0;
    #1 chk({tag, "_after_we"}, pht_we, 1'b0);
  endtask

  initial begin
    reset = 1'b1; upd_valid = 1'b0; upd_index = '0; upd_taken = 1'b0; flush = 1'b0;
    lkp_valid = 1'b1; lkp_index = 8'h77; rd_data = 2'b00;
    tick();
    chk("rst_init_busy", init_busy, 1'b1);
    chk("rst_ready", upd_ready, 1'b0);
    chk("rst_grant", lkp_grant, 1'b0);
    chk("rst_we", pht_we, 1'b1);
    chk("rst_widx", pht_widx, 8'h00);
    chk("rst_wdata", pht_wdata, 2'b01);
    tick();
    reset = 1'b0;
    run_init("a");

    // Counter updates including both saturation limits
    do_update("u5t", 8'd5, 1'b1, 2'b01, 2'b10);
    do_update("u7n", 8'd7, 1'b0, 2'b00, 2'b00);
    do_update("u7t", 8'd7, 1'b1, 2'b11, 2'b11);
    do_update("u9n", 8'd9, 1'b0, 2'b10, 2'b01);

    // Fill while fetch holds the port; starvation limit forces the update through
    lkp_valid = 1'b1; lkp_index = 8'h40; rd_data = 2'b01;
    upd_valid = 1'b1; upd_taken = 1'b1;
    upd_index = 8'd10; #1 chk("c_ready0", upd_ready, 1'b1); tick();
    upd_index = 8'd11; #1 chk("c_ready1", upd_ready, 1'b1); tick();
    upd_index = 8'd12; tick();
    upd_index = 8'd13; #1 chk("c_ready3", upd_ready, 1'b1); tick();
    upd_index = 8'd14;
    #1 chk("c_full", upd_ready, 1'b0);
    chk("c_idle_grant4", lkp_grant, 1'b1);
    chk("c_idle_we4", pht_we, 1'b0);
    tick();
    #1 chk("c_full5", upd_ready, 1'b0);
    chk("c_idle_grant5", lkp_grant, 1'b1);
    chk("c_idle_rdidx5", rd_idx, 8'h40);
    tick();
    #1 chk("c_read_grant", lkp_grant, 1'b0);
    chk("c_read_idx", rd_idx, 8'd10);
    tick();
    #1 chk("c_wr_we", pht_we, 1'b1);
    chk("c_wr_idx", pht_widx, 8'd10);
    chk("c_wr_data", pht_wdata, 2'b10);
    chk("c_full_with_pop", upd_ready, 1'b0);
    tick();
    #1 chk("c_ready_after_pop", upd_ready, 1'b1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; upd_valid = 1'b0; lkp_valid = 1'b0; lkp_index = 8'h55;
    #1 chk("c_flush_rdidx", rd_idx, 8'h55);
    chk("c_flush_we", pht_we, 1'b0);
    chk("c_flush_ready", upd_ready, 1'b1);
    tick();
    #1 chk("c_flush_stay", rd_idx, 8'h55);
    chk("c_flush_stay_we", pht_we, 1'b0);
    tick();

    // Flush in a READ with three entries queued
    upd_valid = 1'b1; upd_taken = 1'b0;
    upd_index = 8'd20; tick();
    upd_index = 8'd21; tick();
    upd_index = 8'd22; rd_data = 2'b10;
    #1 chk("d_read_a", rd_idx, 8'd20);
    tick();
    upd_index = 8'd23;
    #1 chk("d_wr_we", pht_we, 1'b1);
    chk("d_wr_idx", pht_widx, 8'd20);
    chk("d_wr_data", pht_wdata, 2'b01);
    chk("d_wr_ready", upd_ready, 1'b1);
    tick();
    upd_valid = 1'b0;
    #1 chk("d_idle_we", pht_we, 1'b0);
    chk("d_idle_rdidx", rd_idx, 8'h55);
    tick();
    upd_valid = 1'b1; upd_index = 8'd24; flush = 1'b1;
    #1 chk("d_read_b", rd_idx, 8'd21);
    chk("d_flush_ready", upd_ready, 1'b0);
    chk("d_flush_read_we", pht_we, 1'b0);
    tick();
    upd_valid = 1'b0; flush = 1'b0;
    #1 chk("d_no_write", pht_we, 1'b0);
    chk("d_idle_rdidx2", rd_idx, 8'h55);
    chk("d_empty_ready", upd_ready, 1'b1);
    tick();
    #1 chk("d_stay_idle", rd_idx, 8'h55);
    chk("d_stay_we", pht_we, 1'b0);
    tick();

    // Reset pulsed during a WRITE with two entries still queued
    upd_valid = 1'b1; upd_taken = 1'b1;
    upd_index = 8'd30; tick();
    upd_index = 8'd31; tick();
    upd_index = 8'd32; rd_data = 2'b01; tick();
    upd_valid = 1'b0;
    #1 chk("e_wr_we", pht_we, 1'b1);
    chk("e_wr_idx", pht_widx, 8'd30);
    lkp_valid = 1'b1;
    #1 reset = 1'b1;
    #1 chk("e_rst_busy", init_busy, 1'b1);
    chk("e_rst_we", pht_we, 1'b1);
    chk("e_rst_widx", pht_widx, 8'h00);
    chk("e_rst_wdata", pht_wdata, 2'b01);
    chk("e_rst_ready", upd_ready, 1'b0);
    chk("e_rst_grant", lkp_grant, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    run_init("e");
    lkp_index = 8'h55;
    #1 chk("e_empty_rdidx", rd_idx, 8'h55);
    chk("e_empty_we", pht_we, 1'b0);
    tick();
    #1 chk("e_empty_rdidx2", rd_idx, 8'h55);
    chk("e_empty_we2", pht_we, 1'b0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
